// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch unit:
// redirect select codes, default widths and the queue entry layout.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_DEPTH  = 4;

    typedef enum logic [1:0] {
        SEL_BRANCH = 2'b00,
        SEL_JUMP   = 2'b01,
        SEL_REG    = 2'b10,
        SEL_RSVD   = 2'b11
    } redir_sel_e;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_data,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end

    assign o_data  = r_mem[r_rd];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch with prefetch queue, credit-limited issue and PC redirect.
// Define FETCH_STALL_CNT_EN to add stall_cnt / drop_cnt statistics ports.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [DATA_W-1:0] im_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [ADDR_W-1:0] se_16,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       drop_cnt,
`endif
    input  logic              redir_valid,
    input  logic [1:0]        redir_sel,
    input  logic [ADDR_W-1:0] redir_addr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = DATA_W + ADDR_W;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ack_pc;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_drop;

    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic [EW-1:0]     w_head;
    logic              w_valid;
    logic              w_taken;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_ack_drop;
    logic [CW:0]       w_credit;
    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_target;

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  ({im_rdata, r_ack_pc}),
        .i_pop   (w_pop),
        .i_flush (w_taken),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_valid  = reset & ~w_empty;
    assign ir_valid = w_valid;
    assign ir_out   = w_valid ? w_head[EW-1:ADDR_W] : '0;
    assign ir_pc    = w_valid ? w_head[ADDR_W-1:0] : '0;
    assign se_16    = {{(ADDR_W-16){ir_out[15]}}, ir_out[15:0]};
    assign w_pc4    = ir_pc + ADDR_W'(4);

    always_comb begin
        w_target = redir_addr;
        unique case (1'b1)
            (redir_sel == SEL_BRANCH):
                w_target = w_pc4 + {se_16[ADDR_W-3:0], 2'b00};
            (redir_sel == SEL_JUMP):
                w_target = {w_pc4[ADDR_W-1:28], ir_out[25:0], 2'b00};
            default: w_target = redir_addr;
        endcase
    end

    // Branch/jump targets come from the head, so they need a valid head
    assign w_taken = redir_valid & ((redir_sel == SEL_REG) |
                     (((redir_sel == SEL_BRANCH) | (redir_sel == SEL_JUMP)) & w_valid));

    assign w_credit   = {1'b0, w_count} + {1'b0, r_inflight};
    assign w_issue    = reset & ~w_taken & (w_credit < (CW+1)'(DEPTH));
    assign w_ack_drop = im_ack & (w_taken | (r_drop != '0));
    assign w_push     = im_ack & ~w_ack_drop;
    assign w_pop      = w_valid & ir_ready & ~w_taken;

    assign im_req  = w_issue;
    assign im_addr = r_pc;

    // r_ack_pc tracks the address of the oldest non-stale outstanding read
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_ack_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_issue) - CW'(im_ack);
            if (w_taken) begin
                r_pc     <= w_target;
                r_ack_pc <= w_target;
                r_drop   <= r_inflight - CW'(im_ack);
            end else begin
                if (w_issue) r_pc <= r_pc + ADDR_W'(4);
                if (w_push) r_ack_pc <= r_ack_pc + ADDR_W'(4);
                if (im_ack && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (ir_ready && !w_valid && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_ack_drop && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit with a variable-latency memory model.
// Expected instructions are queued at issue and compared when they reach the head.
module tb_fetch_queue_unit;
    import fetch_pkg::*;

    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic [31:0] se_16;
    logic        redir_valid;
    logic [1:0]  redir_sel;
    logic [31:0] redir_addr;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEP),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_out      (ir_out),
        .ir_pc       (ir_pc),
        .se_16       (se_16),
        .redir_valid (redir_valid),
        .redir_sel   (redir_sel),
        .redir_addr  (redir_addr)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t        pend[$];
    fetch_entry_t expq[$];
    int           cyc;
    int           epoch;
    int           arrived;
    int           lat;
    logic [31:0]  exp_pc;
    int           n_vec;
    int           n_err;
    logic         s_req;
    logic         s_valid;
    logic [31:0]  s_addr;
    logic [31:0]  s_pc;
    logic [31:0]  s_out;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h1000_FFFE;
        return {8'hA5, a[23:0]};
    endfunction

    function automatic logic [31:0] sx16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] tgt(input logic [1:0] sel,
                                        input fetch_entry_t h,
                                        input logic [31:0] ra);
        logic [31:0] p4;
        p4 = h.pc + 32'd4;
        if (sel == 2'b00) return p4 + {{14{h.instr[15]}}, h.instr[15:0], 2'b00};
        if (sel == 2'b01) return {p4[31:28], h.instr[25:0], 2'b00};
        return ra;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic rst, input logic rdy, input logic rv,
                        input logic [1:0] sel, input logic [31:0] ra);
        logic         taken;
        logic         mv;
        logic         ereq;
        logic         ack;
        mreq_t        a;
        fetch_entry_t h;
        @(negedge clk);
        cyc++;
        reset       = rst;
        ir_ready    = rdy;
        redir_valid = rv;
        redir_sel   = sel;
        redir_addr  = ra;
        ack = rst && (pend.size() > 0) && (pend[0].due == cyc);
        im_ack   = ack;
        im_rdata = ack ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
        #1;
        s_req   = im_req;
        s_addr  = im_addr;
        s_valid = ir_valid;
        s_pc    = ir_pc;
        s_out   = ir_out;
        if (!rst) begin
            check_eq("rst_im_req", 32'(im_req), 32'h0);
            check_eq("rst_ir_valid", 32'(ir_valid), 32'h0);
            check_eq("rst_ir_out", ir_out, 32'h0);
            check_eq("rst_ir_pc", ir_pc, 32'h0);
            pend.delete();
            expq.delete();
            arrived = 0;
            epoch++;
            exp_pc = 32'h0;
            return;
        end
        mv = (arrived > 0);
        check_eq("ir_valid", 32'(ir_valid), 32'(mv));
        if (mv) begin
            check_eq("ir_pc", ir_pc, expq[0].pc);
            check_eq("ir_out", ir_out, expq[0].instr);
            check_eq("se_16", se_16, sx16(expq[0].instr[15:0]));
        end
        taken = rv && ((sel == 2'b10) || ((sel <= 2'b01) && mv));
        ereq  = !taken && ((arrived + pend.size()) < DEP);
        check_eq("im_req", 32'(im_req), 32'(ereq));
        if (im_req && ereq) check_eq("im_addr", im_addr, exp_pc);
        if (ack) begin
            a = pend.pop_front();
            if (!taken && (a.epoch == epoch)) arrived++;
        end
        if (taken) begin
            h = '0;
            if (expq.size() > 0) h = expq[0];
            exp_pc = tgt(sel, h, ra);
            expq.delete();
            arrived = 0;
            epoch++;
        end else begin
            if (mv && rdy) begin
                void'(expq.pop_front());
                arrived--;
            end
            if (ereq) begin
                expq.push_back('{instr: mem_word(exp_pc), pc: exp_pc});
                exp_pc += 32'd4;
            end
        end
        if (im_req) pend.push_back('{addr: im_addr, due: cyc + lat, epoch: epoch});
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp_head);
        int found;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
            if (s_valid) begin
                check_eq(tag, s_pc, exp_head);
                found = 1;
                break;
            end
        end
        if (found == 0) check_eq({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        int          first;
        int          nreq;
        int          found;
        logic [31:0] p;
        logic [31:0] jexp;
        fetch_entry_t hd;
        reset = 1'b0; ir_ready = 1'b0; redir_valid = 1'b0;
        redir_sel = 2'b00; redir_addr = 32'h0;
        im_ack = 1'b0; im_rdata = 32'h0;
        lat = 1; cyc = 0; epoch = 0; arrived = 0; exp_pc = 32'h0;
        n_vec = 0; n_err = 0;

        // streaming, latency 1
        repeat (2) step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
            if (s_valid && (first == 0)) first = i;
        end
        check_eq("t1_first_valid", 32'(first), 32'd3);

        // backpressure: credit limit
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
            if (s_req) nreq++;
        end
        check_eq("t2_req_count", 32'(nreq), 32'd4);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        check_eq("t2_no_req_at_pop", 32'(s_req), 32'h0);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        check_eq("t2_resume_req", 32'(s_req), 32'h1);

        // branch from head 0x1000_FFFE at 0x40
        step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
            if ((arrived > 0) && (expq[0].pc == 32'h40)) begin
                found = 1;
                break;
            end
        end
        check_eq("t3_reach_0x40", 32'(found), 32'h1);
        step(1'b1, 1'b1, 1'b1, SEL_BRANCH, 32'h0);
        check_eq("t3_head_instr", s_out, 32'h1000_FFFE);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        check_eq("t3_flushed", 32'(s_valid), 32'h0);
        check_eq("t3_target", s_addr, 32'h3C);
        check_eq("t3_target_req", 32'(s_req), 32'h1);
        wait_valid("t3_head_pc", 32'h3C);

        // reserved select is ignored
        repeat (3) step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        p = s_addr;
        step(1'b1, 1'b1, 1'b1, SEL_RSVD, 32'h999);
        check_eq("t5_rsvd_valid", 32'(s_valid), 32'h1);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        check_eq("t5_rsvd_seq", s_addr, p + 32'd8);

        // branch with no valid head is ignored
        step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        step(1'b1, 1'b1, 1'b1, SEL_BRANCH, 32'h0);
        check_eq("t5_novalid_req", 32'(s_req), 32'h1);
        check_eq("t5_novalid_addr", s_addr, 32'h0);
        step(1'b1, 1'b1, 1'b1, SEL_JUMP, 32'h0);
        check_eq("t5_novalid_seq", s_addr, 32'h4);

        // latency 3, register redirect with 2 in flight
        step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        lat = 3;
        repeat (2) step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
        check_eq("t4_inflight", 32'(pend.size()), 32'd2);
        step(1'b1, 1'b0, 1'b1, SEL_REG, 32'h200);
        wait_valid("t4_reg_pc", 32'h200);
        repeat (6) step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);

        // back-to-back redirects, wrap-around target
        step(1'b1, 1'b1, 1'b1, SEL_REG, 32'h1000);
        step(1'b1, 1'b1, 1'b1, SEL_REG, 32'hFFFF_FFF8);
        wait_valid("t4_wrap_pc", 32'hFFFF_FFF8);
        repeat (4) step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);

        // jump from head
        hd = expq[0];
        jexp = tgt(SEL_JUMP, hd, 32'h0);
        step(1'b1, 1'b1, 1'b1, SEL_JUMP, 32'h0);
        check_eq("t4_jump_head", s_pc, hd.pc);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        check_eq("t4_jump_addr", s_addr, jexp);
        repeat (8) step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        step(1'b1, 1'b1, 1'b1, SEL_BRANCH, 32'h0);
        repeat (8) step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);

        // reset mid-stream with full queue
        lat = 1;
        step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
        repeat (8) step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
        check_eq("t6_full", 32'(arrived), 32'd4);
        step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
        check_eq("t6_rst_valid", 32'(s_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);
        check_eq("t6_release_addr", s_addr, 32'h0);
        check_eq("t6_release_req", 32'(s_req), 32'h1);
        check_eq("t6_release_valid", 32'(s_valid), 32'h0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 2'b00, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
